// File: rtl/mmio_resp.sv
// Bus responder for the SLC3 CPU memory side: decodes each access to either a small MMIO
// register bank (switches, hex, LEDs, countdown timer) or external SRAM with fixed wait states.
module mmio_resp #(
    parameter logic [15:0] MMIO_BASE   = 16'hFFF0,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_o,
    output logic [15:0] led_o,
    output logic        tmr_irq,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

    localparam logic [15:0] ADDR_SW   = 16'hFFFF;
    localparam logic [15:0] ADDR_HEX  = 16'hFFFE;
    localparam logic [15:0] ADDR_LED  = 16'hFFFD;
    localparam logic [15:0] ADDR_TCNT = 16'hFFFC;
    localparam logic [15:0] ADDR_TCTL = 16'hFFFB;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_wcnt;
    logic        r_we;
    logic [15:0] r_rdata, r_hex, r_led, r_tcnt;
    logic        r_ten, r_texp;
    logic [15:0] r_sw_meta, r_sw_sync;
    logic        r_sram_ce, r_sram_we;
    logic [15:0] r_sram_addr, r_sram_wdata;

    logic        w_accept, w_is_mmio, w_mmio_wr, w_mmio_rd, w_sram_start, w_sram_done;
    logic        w_wr_hex, w_wr_led, w_wr_tcnt, w_wr_tctl;
    logic        w_tmr_dec, w_tmr_expire;
    logic [15:0] w_mmio_rdata;

    assign w_accept     = (r_state == StIdle) && req;
    assign w_is_mmio    = (addr >= MMIO_BASE);
    assign w_mmio_wr    = w_accept && w_is_mmio && we;
    assign w_mmio_rd    = w_accept && w_is_mmio && !we;
    assign w_sram_start = w_accept && !w_is_mmio;
    assign w_sram_done  = (r_state == StWait) && (r_wcnt == 4'd0);

    assign w_wr_hex  = w_mmio_wr && (addr == ADDR_HEX);
    assign w_wr_led  = w_mmio_wr && (addr == ADDR_LED);
    assign w_wr_tcnt = w_mmio_wr && (addr == ADDR_TCNT);
    assign w_wr_tctl = w_mmio_wr && (addr == ADDR_TCTL);

    // A TCNT write overrides the decrement, so it also suppresses the expiry it would cause.
    assign w_tmr_dec    = r_ten && (r_tcnt != 16'd0);
    assign w_tmr_expire = w_tmr_dec && (r_tcnt == 16'd1) && !w_wr_tcnt;

    always_comb begin
        w_mmio_rdata = 16'h0000;
        case (addr)
            ADDR_SW:   w_mmio_rdata = r_sw_sync;
            ADDR_HEX:  w_mmio_rdata = r_hex;
            ADDR_LED:  w_mmio_rdata = r_led;
            ADDR_TCNT: w_mmio_rdata = r_tcnt;
            ADDR_TCTL: w_mmio_rdata = {14'd0, r_texp, r_ten};
            default:   w_mmio_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (req) w_state_next = w_is_mmio ? StResp : StWait;
            StWait:  if (r_wcnt == 4'd0) w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt       <= 4'd0;
            r_we         <= 1'b0;
            r_rdata      <= 16'h0000;
            r_sram_ce    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= 16'h0000;
            r_sram_wdata <= 16'h0000;
        end else begin
            if (w_mmio_rd) r_rdata <= w_mmio_rdata;
            if (w_sram_start) begin
                r_wcnt       <= WAIT_INIT;
                r_we         <= we;
                r_sram_ce    <= 1'b1;
                r_sram_we    <= we;
                r_sram_addr  <= addr;
                r_sram_wdata <= wdata;
            end else if (w_sram_done) begin
                if (!r_we) r_rdata <= sram_rdata;
                r_sram_ce <= 1'b0;
                r_sram_we <= 1'b0;
            end else if (r_state == StWait) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hex     <= 16'h0000;
            r_led     <= 16'h0000;
            r_tcnt    <= 16'h0000;
            r_ten     <= 1'b0;
            r_texp    <= 1'b0;
            r_sw_meta <= 16'h0000;
            r_sw_sync <= 16'h0000;
        end else begin
            r_sw_meta <= sw_i;
            r_sw_sync <= r_sw_meta;
            if (w_wr_hex) r_hex <= wdata;
            if (w_wr_led) r_led <= wdata;
            if (w_wr_tcnt)      r_tcnt <= wdata;
            else if (w_tmr_dec) r_tcnt <= r_tcnt - 16'd1;
            if (w_wr_tctl) r_ten <= wdata[0];
            // Expiry beats a simultaneous write-1-to-clear.
            if (w_tmr_expire)                r_texp <= 1'b1;
            else if (w_wr_tctl && wdata[1]) r_texp <= 1'b0;
        end
    end

    assign ready      = (r_state == StResp);
    assign rdata      = r_rdata;
    assign hex_o      = r_hex;
    assign led_o      = r_led;
    assign tmr_irq    = r_texp;
    assign sram_ce    = r_sram_ce;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_mmio_resp.sv
// Directed bench for mmio_resp: a scoreboard queue holds the expected response of each access
// and is drained as ready pulses arrive.
module tb_mmio_resp;

    localparam int unsigned WS = 2;

    logic        clk, reset, req, we;
    logic [15:0] addr, wdata, rdata, sw_i, hex_o, led_o;
    logic        ready, tmr_irq, sram_ce, sram_we;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        int          lat;
        int          ce;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [0:255];

    mmio_resp #(.MMIO_BASE(16'hFFF0), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .sw_i(sw_i), .hex_o(hex_o), .led_o(led_o),
        .tmr_irq(tmr_irq), .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple SRAM: stores on write-enabled cycles, reads combinationally.
    always @(posedge clk) if (sram_ce && sram_we) mem[sram_addr[7:0]] <= sram_wdata;
    assign sram_rdata = mem[sram_addr[7:0]];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge after the cycle following ready.
    task automatic access(input string tag, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd);
        exp_t e, got;
        int lat, ce_cnt;
        e.rd   = !w;
        e.data = exp_rd;
        e.lat  = (a >= 16'hFFF0) ? 1 : 1 + WS;
        e.ce   = (a >= 16'hFFF0) ? 0 : WS;
        sb.push_back(e);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0; ce_cnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (sram_ce) ce_cnt++;
        end while (!ready && lat < 20);
        req = 1'b0;
        got = sb.pop_front();
        check({tag, "_lat"}, 16'(lat), 16'(got.lat));
        check({tag, "_ce_cycles"}, 16'(ce_cnt), 16'(got.ce));
        if (got.rd) check({tag, "_rdata"}, rdata, got.data);
        @(negedge clk);
        check({tag, "_ready_pulse"}, 16'(ready), 16'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw_i = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_led", led_o, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        // Abort an SRAM read in WAIT with an asynchronous reset.
        req = 1'b1; we = 1'b0; addr = 16'h3000;
        @(negedge clk);
        check("wait_ce", 16'(sram_ce), 16'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", 16'(ready), 16'd0);
        check("abort_ce", 16'(sram_ce), 16'd0);
        check("abort_hex", hex_o, 16'h0000);
        check("abort_irq", 16'(tmr_irq), 16'd0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_resp", 16'(ready), 16'd0);

        access("wr_hex", 1'b1, 16'hFFFE, 16'hBEEF, 16'h0000);
        check("hex_o", hex_o, 16'hBEEF);
        access("rd_hex", 1'b0, 16'hFFFE, 16'h0000, 16'hBEEF);
        access("wr_led", 1'b1, 16'hFFFD, 16'h5A5A, 16'h0000);
        check("led_o", led_o, 16'h5A5A);
        access("rd_led", 1'b0, 16'hFFFD, 16'h0000, 16'h5A5A);

        sw_i = 16'h00A5;
        repeat (3) @(negedge clk);
        access("rd_sw", 1'b0, 16'hFFFF, 16'h0000, 16'h00A5);
        access("rd_unmapped", 1'b0, 16'hFFF3, 16'h0000, 16'h0000);
        access("wr_sw", 1'b1, 16'hFFFF, 16'h1111, 16'h0000);
        access("rd_sw_after_wr", 1'b0, 16'hFFFF, 16'h0000, 16'h00A5);

        access("sram_wr0", 1'b1, 16'h3000, 16'h1234, 16'h0000);
        access("sram_wr1", 1'b1, 16'h3001, 16'h5678, 16'h0000);
        access("sram_rd0", 1'b0, 16'h3000, 16'h0000, 16'h1234);
        access("sram_rd1", 1'b0, 16'h3001, 16'h0000, 16'h5678);

        // Enable lands on edge E; the task returns after E+1, so expiry is seen after E+3.
        access("wr_tcnt3", 1'b1, 16'hFFFC, 16'd3, 16'h0000);
        access("wr_tctl_en", 1'b1, 16'hFFFB, 16'h0001, 16'h0000);
        check("irq_e1", 16'(tmr_irq), 16'd0);
        @(negedge clk);
        check("irq_e2", 16'(tmr_irq), 16'd0);
        @(negedge clk);
        check("irq_e3", 16'(tmr_irq), 16'd1);
        access("rd_tcnt_zero", 1'b0, 16'hFFFC, 16'h0000, 16'h0000);
        access("rd_tctl_exp", 1'b0, 16'hFFFB, 16'h0000, 16'h0003);
        access("clr_exp", 1'b1, 16'hFFFB, 16'h0003, 16'h0000);
        check("irq_cleared", 16'(tmr_irq), 16'd0);
        access("rd_tctl_en", 1'b0, 16'hFFFB, 16'h0000, 16'h0001);

        // Write 50 while counting down from 100; one decrement follows before the read samples.
        access("wr_tcnt100", 1'b1, 16'hFFFC, 16'd100, 16'h0000);
        access("wr_tcnt50", 1'b1, 16'hFFFC, 16'd50, 16'h0000);
        access("rd_tcnt49", 1'b0, 16'hFFFC, 16'h0000, 16'd49);

        // Count 2 reaches 0 on the same edge that the TCTL clear is accepted.
        access("wr_tcnt2", 1'b1, 16'hFFFC, 16'd2, 16'h0000);
        access("clr_on_expiry", 1'b1, 16'hFFFB, 16'h0003, 16'h0000);
        check("irq_set_wins", 16'(tmr_irq), 16'd1);
        access("rd_tctl_set_wins", 1'b0, 16'hFFFB, 16'h0000, 16'h0003);
        access("clr_exp2", 1'b1, 16'hFFFB, 16'h0003, 16'h0000);
        access("wr_tcnt0", 1'b1, 16'hFFFC, 16'd0, 16'h0000);
        repeat (2) @(negedge clk);
        check("tcnt0_no_irq", 16'(tmr_irq), 16'd0);

        // req held through RESP: one pulse over two cycles.
        req = 1'b1; we = 1'b0; addr = 16'hFFFD;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        req = 1'b0;
        check("hold_one_pulse", 16'(pulses), 16'd1);
        check("hold_rdata", rdata, 16'h5A5A);
        repeat (2) @(negedge clk);

        // req held for four cycles: second access only after IDLE is re-entered.
        req = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        req = 1'b0;
        @(negedge clk);
        if (ready) pulses++;
        check("hold_two_pulses", 16'(pulses), 16'd2);

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
